// File: rtl/gear_shifter_if.sv
// Gear request / engaged-gear status bundle between the gear selector side and gear_shifter.
// The master drives the request; the slave (gear_shifter) drives the status.
interface gear_shifter_if;
  logic [2:0] gear_req;
  logic [2:0] gear_cur;
  logic [5:0] gear_led;
  logic       shifting;
  logic       shift_up;
  logic       shift_done;

  modport master (
    output gear_req,
    input  gear_cur,
    input  gear_led,
    input  shifting,
    input  shift_up,
    input  shift_done
  );

  modport slave (
    input  gear_req,
    output gear_cur,
    output gear_led,
    output shifting,
    output shift_up,
    output shift_done
  );
endinterface

// File: rtl/gear_shifter.sv
// Walks the engaged gear one step at a time toward the requested gear, with a fixed dwell per step.
// Optional macro GEAR_SHIFT_BLINK_EN blinks the target-gear LED while a step is in progress.
module gear_shifter #(
  parameter int unsigned SHIFT_CYCLES = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input logic           clk,
  input logic           rst,
  gear_shifter_if.slave bus
);

  localparam int unsigned    DW         = $clog2(SHIFT_CYCLES + 1);
  localparam logic [DW-1:0]  DWELL_LOAD = DW'(SHIFT_CYCLES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    gear_q, gear_d;
  logic [2:0]    target_q, target_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          up_q, up_d;
  logic          done_q, done_d;

  logic [2:0]    req_eff;
  logic          start_step;
  logic          target_lit;
  logic [5:0]    led_vec;

  // Request 7 has no gear behind it; treat it as top gear.
  assign req_eff    = (bus.gear_req == 3'd7) ? 3'd6 : bus.gear_req;
  assign start_step = (state_q == S_IDLE) && (req_eff != gear_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gear_q   <= 3'd0;
      target_q <= 3'd0;
      dwell_q  <= '0;
      up_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gear_q   <= gear_d;
      target_q <= target_d;
      dwell_q  <= dwell_d;
      up_q     <= up_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gear_d   = gear_q;
    target_d = target_q;
    dwell_d  = dwell_q;
    up_d     = up_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_step) begin
          state_d  = S_SHIFT;
          up_d     = (req_eff > gear_q);
          target_d = (req_eff > gear_q) ? (gear_q + 3'd1) : (gear_q - 3'd1);
          dwell_d  = DWELL_LOAD;
        end
      end
      S_SHIFT: begin
        // The request is not looked at here, so a step can never be reversed mid-dwell.
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DW'(1);
        end else begin
          gear_d  = target_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef GEAR_SHIFT_BLINK_EN
  localparam int unsigned   BW         = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (start_step) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if ((state_q == S_SHIFT) && (dwell_q != '0)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign target_lit = (state_q == S_SHIFT) && blink_ph_q;
`else
  assign target_lit = 1'b0;
`endif

  // Bit gi lights for gear gi+1; gear 0 (neutral) has no LED.
  for (genvar gi = 0; gi < 6; gi++) begin : g_led
    assign led_vec[gi] = (gear_q == 3'(gi + 1)) || (target_lit && (target_q == 3'(gi + 1)));
  end

  always_comb begin
    bus.gear_cur   = gear_q;
    bus.gear_led   = led_vec;
    bus.shifting   = (state_q == S_SHIFT);
    bus.shift_up   = up_q;
    bus.shift_done = done_q;
  end

endmodule

// File: tb/tb_gear_shifter.sv
// Self-checking bench for gear_shifter: directed scenarios followed by random requests and resets,
// compared every cycle against a timestamp-based model of the gear walk.
module tb_gear_shifter;

  localparam int SC = 4;
  localparam int BC = 2;

  logic clk;
  logic rst;

  gear_shifter_if bus_if ();

  gear_shifter #(
    .SHIFT_CYCLES (SC),
    .BLINK_CYCLES (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // Model: a step is described by the cycle it started and its target.
  int       cyc = 0;
  int       m_gear = 0;
  int       m_target = 0;
  bit       m_busy = 0;
  bit       m_up = 0;
  bit       m_done = 0;
  int       m_start = 0;

  function automatic logic [5:0] onehot(int g);
    logic [5:0] v;
    v = 6'b0;
    if (g >= 1 && g <= 6) v[g-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [5:0] exp_led();
    logic [5:0] v;
    v = onehot(m_gear);
`ifdef GEAR_SHIFT_BLINK_EN
    if (m_busy && (((cyc - m_start) / BC) % 2 == 0)) v = v | onehot(m_target);
`endif
    return v;
  endfunction

  task automatic model_edge();
    int req;
    cyc++;
    m_done = 0;
    req = (bus_if.gear_req == 3'd7) ? 6 : int'(bus_if.gear_req);
    if (rst) begin
      m_gear = 0; m_target = 0; m_busy = 0; m_up = 0;
    end else if (m_busy) begin
      if (cyc - m_start == SC) begin
        m_gear = m_target; m_busy = 0; m_done = 1;
      end
    end else if (req != m_gear) begin
      m_busy   = 1;
      m_start  = cyc;
      m_up     = (req > m_gear);
      m_target = m_up ? m_gear + 1 : m_gear - 1;
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("gear_cur",   8'(bus_if.gear_cur),   8'(m_gear));
    chk("gear_led",   8'(bus_if.gear_led),   8'(exp_led()));
    chk("shifting",   8'(bus_if.shifting),   8'(m_busy));
    chk("shift_up",   8'(bus_if.shift_up),   8'(m_up));
    chk("shift_done", 8'(bus_if.shift_done), 8'(m_done));
    if (bus_if.shift_done === 1'b1) done_seen++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [5:0] blink_exp [4];

  initial begin
    rst = 1'b1;
    bus_if.gear_req = 3'd0;
    ticks(3);
    rst = 1'b0;

    // Neutral held: nothing moves for 20 cycles.
    done_seen = 0;
    ticks(20);
    chk("idle_done_count", 8'(done_seen), 8'd0);
    chk("idle_led", 8'(bus_if.gear_led), 8'b0);

    // 0 -> 3: three up steps, gear_cur changes after E4, E9, E14.
    done_seen = 0;
    bus_if.gear_req = 3'd3;
    ticks(4);
    chk("first_step_pending", 8'(bus_if.gear_cur), 8'd0);
    tick();
    chk("first_step_gear", 8'(bus_if.gear_cur), 8'd1);
    ticks(10);
    chk("up3_gear", 8'(bus_if.gear_cur), 8'd3);
    chk("up3_done_count", 8'(done_seen), 8'd3);
    chk("up3_led", 8'(bus_if.gear_led), 8'b000100);
    chk("up3_dir", 8'(bus_if.shift_up), 8'd1);

    // 3 -> 1, then request 7 clamps to 6.
    bus_if.gear_req = 3'd1;
    ticks(10);
    chk("down1_gear", 8'(bus_if.gear_cur), 8'd1);
    chk("down1_led", 8'(bus_if.gear_led), 8'b000001);
    chk("down1_dir", 8'(bus_if.shift_up), 8'd0);
    bus_if.gear_req = 3'd7;
    ticks(31);
    chk("clamp_gear", 8'(bus_if.gear_cur), 8'd6);
    chk("clamp_led", 8'(bus_if.gear_led), 8'b100000);
    chk("clamp_idle", 8'(bus_if.shifting), 8'd0);

    // From 2, request 4 then 1 two cycles in: 2->3 finishes, then 3->2->1.
    bus_if.gear_req = 3'd2;
    ticks(20);
    chk("at2_gear", 8'(bus_if.gear_cur), 8'd2);
    bus_if.gear_req = 3'd4;
    ticks(3);
    bus_if.gear_req = 3'd1;
    ticks(2);
    chk("no_reverse_gear", 8'(bus_if.gear_cur), 8'd3);
    ticks(10);
    chk("after_reverse_gear", 8'(bus_if.gear_cur), 8'd1);

    // From 1 step to 2: target LED blinks (or stays dark without the blink option).
`ifdef GEAR_SHIFT_BLINK_EN
    blink_exp = '{6'b000011, 6'b000011, 6'b000001, 6'b000001};
`else
    blink_exp = '{6'b000001, 6'b000001, 6'b000001, 6'b000001};
`endif
    bus_if.gear_req = 3'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("blink_led", 8'(bus_if.gear_led), 8'(blink_exp[i]));
    end
    tick();
    chk("blink_end_led", 8'(bus_if.gear_led), 8'b000010);

    // Reset two cycles into a 4->5 step, then five up steps from neutral.
    bus_if.gear_req = 3'd4;
    ticks(10);
    chk("at4_gear", 8'(bus_if.gear_cur), 8'd4);
    bus_if.gear_req = 3'd5;
    ticks(3);
    rst = 1'b1;
    done_seen = 0;
    tick();
    chk("rst_gear", 8'(bus_if.gear_cur), 8'd0);
    chk("rst_shifting", 8'(bus_if.shifting), 8'd0);
    chk("rst_led", 8'(bus_if.gear_led), 8'd0);
    chk("rst_done_count", 8'(done_seen), 8'd0);
    rst = 1'b0;
    ticks(25);
    chk("post_rst_gear", 8'(bus_if.gear_cur), 8'd5);
    chk("post_rst_done_count", 8'(done_seen), 8'd5);

    // Random requests with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) bus_if.gear_req = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
